// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Stall vector bit order: [0]pc [1]if [2]id [3]ex [4]mem [5]wb, 1 = hold.
package pipe_ctrl_pkg;

    localparam int STALL_W      = 6;
    localparam int PERF_STALL_W = 32;
    localparam int PERF_FLUSH_W = 16;

    typedef logic [STALL_W-1:0] stall_t;

    // Each stall code freezes its stage and everything upstream of it.
    localparam stall_t STALL_NONE = 6'b000000;
    localparam stall_t STALL_IF   = 6'b000011;
    localparam stall_t STALL_ID   = 6'b000111;
    localparam stall_t STALL_EX   = 6'b001111;

    typedef enum logic [1:0] {
        PCS_RUN   = 2'd0,
        PCS_MC    = 2'd1,
        PCS_FLUSH = 2'd2
    } pcs_e;

endpackage

// File: rtl/pipe_mc_timer.sv
// Countdown timer for EX multi-cycle ops. Loaded with len-2 on the start cycle,
// so last_o rises in the final stalled cycle; abort drops it without a last pulse.
module pipe_mc_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int MCLEN_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [MCLEN_W-1:0] len_i,
    input  logic               abort_i,
    output logic               busy_o,
    output logic               last_o
);

    logic [MCLEN_W-1:0] cnt_q, cnt_d;
    logic               busy_q, busy_d;

    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (abort_i) begin
            cnt_d  = '0;
            busy_d = 1'b0;
        end else if (load_i) begin
            // The start cycle and the final cycle are both outside the countdown.
            cnt_d  = len_i - MCLEN_W'(2);
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q - MCLEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;
    assign last_o = busy_q && (cnt_q == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush sequencer: merges IF/ID/EX stall requests and MEM redirects.
// Define PIPE_CTRL_PERF_EN to add saturating stall/flush cycle counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int MCLEN_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_stallreq_i,
    input  logic               id_stallreq_i,
    input  logic               ex_mc_start_i,
    input  logic [MCLEN_W-1:0] ex_mc_len_i,
    input  logic               flush_req_i,
    input  logic [ADDR_W-1:0]  flush_pc_i,
    output logic [STALL_W-1:0] stall_o,
    output logic               flush_o,
    output logic [ADDR_W-1:0]  new_pc_o,
    output logic               ex_mc_done_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [PERF_STALL_W-1:0] perf_stall_o,
    output logic [PERF_FLUSH_W-1:0] perf_flush_o
`endif
);

    pcs_e              state_q, state_d;
    logic [ADDR_W-1:0] new_pc_q, new_pc_d;
    stall_t            stall_d;
    logic              done_d;
    logic              mc_load, mc_abort, mc_busy, mc_last;

    pipe_mc_timer #(
        .MCLEN_W (MCLEN_W)
    ) u_mc_timer (
        .clk     (clk),
        .rst     (rst),
        .load_i  (mc_load),
        .len_i   (ex_mc_len_i),
        .abort_i (mc_abort),
        .busy_o  (mc_busy),
        .last_o  (mc_last)
    );

    always_comb begin
        state_d  = state_q;
        new_pc_d = new_pc_q;
        stall_d  = STALL_NONE;
        done_d   = 1'b0;
        mc_load  = 1'b0;
        mc_abort = 1'b0;
        if (!rst) begin
            if (flush_req_i) begin
                // A redirect overrides everything, including an in-flight multi-cycle op.
                stall_d  = STALL_ID;
                new_pc_d = flush_pc_i;
                state_d  = PCS_FLUSH;
                mc_abort = (state_q == PCS_MC);
            end else begin
                unique case (state_q)
                    PCS_RUN: begin
                        if (ex_mc_start_i) begin
                            stall_d = STALL_EX;
                            if (ex_mc_len_i <= MCLEN_W'(1)) begin
                                done_d = 1'b1;
                            end else begin
                                mc_load = 1'b1;
                                state_d = PCS_MC;
                            end
                        end else if (id_stallreq_i) begin
                            stall_d = STALL_ID;
                        end else if (if_stallreq_i) begin
                            stall_d = STALL_IF;
                        end
                    end
                    PCS_MC: begin
                        stall_d = STALL_EX;
                        done_d  = mc_last;
                        // An idle timer here would otherwise lock the pipe; fall back to RUN.
                        if (mc_last || !mc_busy) begin
                            state_d = PCS_RUN;
                        end
                    end
                    PCS_FLUSH: begin
                        state_d = PCS_RUN;
                    end
                    default: begin
                        state_d = PCS_RUN;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= PCS_RUN;
            new_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            new_pc_q <= new_pc_d;
        end
    end

    assign stall_o      = stall_d;
    assign ex_mc_done_o = done_d;
    assign flush_o      = (state_q == PCS_FLUSH);
    assign new_pc_o     = new_pc_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [PERF_STALL_W-1:0] perf_stall_q, perf_stall_d;
    logic [PERF_FLUSH_W-1:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if ((stall_d != STALL_NONE) && (perf_stall_q != '1)) begin
            perf_stall_d = perf_stall_q + PERF_STALL_W'(1);
        end
        if ((state_q == PCS_FLUSH) && (perf_flush_q != '1)) begin
            perf_flush_d = perf_flush_q + PERF_FLUSH_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall_o = perf_stall_q;
    assign perf_flush_o = perf_flush_q;
`endif

endmodule
